// File: rtl/exu_opimm_branch_if.sv
// Issue-side and result-side bus of the OP-IMM/BRANCH execute unit.
interface exu_opimm_branch_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) ();

  // Issue side
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [PC_W-1:0]  in_pc;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;

  // Result side
  logic             out_valid;
  logic             out_ready;
  logic             out_rd_we;
  logic [4:0]       out_rd_addr;
  logic [XLEN-1:0]  out_rd_data;
  logic             out_br;
  logic             out_br_taken;
  logic [PC_W-1:0]  out_br_target;
  logic             out_illegal;
  logic [CNT_W-1:0] taken_cnt;

  // Execute unit side
  modport slave (
    input  in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
    output in_ready, out_valid, out_rd_we, out_rd_addr, out_rd_data,
           out_br, out_br_taken, out_br_target, out_illegal, taken_cnt
  );

  // Issue logic / consumer side
  modport master (
    output in_valid, in_inst, in_pc, in_rs1, in_rs2, out_ready,
    input  in_ready, out_valid, out_rd_we, out_rd_addr, out_rd_data,
           out_br, out_br_taken, out_br_target, out_illegal, taken_cnt
  );

endinterface

// File: rtl/exu_opimm_branch.sv
// Two-stage execute unit for RV32I/RV64I OP-IMM and BRANCH instructions.
// S1 holds decoded fields and operands, S2 holds the registered result.
module exu_opimm_branch #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  exu_opimm_branch_if.slave  bus
);

  localparam int unsigned SHW        = (XLEN == 64) ? 6 : 5;
  localparam logic [4:0]  OPC_OPIMM  = 5'b00100;
  localparam logic [4:0]  OPC_BRANCH = 5'b11000;

  typedef enum logic [1:0] {
    KIND_ILL    = 2'd0,
    KIND_OPIMM  = 2'd1,
    KIND_BRANCH = 2'd2
  } kind_e;

  // Decode-side signals
  logic [4:0]      dec_opc;
  logic [2:0]      dec_f3;
  logic [11:0]     dec_imm12;
  logic [11:0]     dec_shift_hi;
  kind_e           dec_kind;
  logic [XLEN-1:0] dec_imm;
  logic [PC_W-1:0] dec_bimm;

  // Stage 1 registers
  logic            s1_valid;
  kind_e           s1_kind;
  logic [2:0]      s1_f3;
  logic [4:0]      s1_rd;
  logic [XLEN-1:0] s1_imm;
  logic [PC_W-1:0] s1_pc;
  logic [PC_W-1:0] s1_bimm;
  logic [XLEN-1:0] s1_rs1;
  logic [XLEN-1:0] s1_rs2;

  // Execute-side signals
  logic            s2_adv;
  logic [SHW-1:0]  ex_shamt;
  logic            ex_rd_we;
  logic [XLEN-1:0] ex_rd_data;
  logic            ex_br;
  logic            ex_taken;
  logic            ex_illegal;

  assign dec_opc      = bus.in_inst[6:2];
  assign dec_f3       = bus.in_inst[14:12];
  assign dec_imm12    = bus.in_inst[31:20];
  assign dec_shift_hi = dec_imm12 >> SHW;
  assign dec_imm      = {{(XLEN-12){dec_imm12[11]}}, dec_imm12};
  assign dec_bimm     = {{(PC_W-13){bus.in_inst[31]}}, bus.in_inst[31], bus.in_inst[7],
                         bus.in_inst[30:25], bus.in_inst[11:8], 1'b0};

  // S2 takes a new entry when empty or its result is being consumed.
  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_adv;

  // Classify the incoming word; shift encodings with stray upper bits are illegal.
  always_comb begin
    dec_kind = KIND_ILL;
    case (dec_opc)
      OPC_OPIMM: begin
        dec_kind = KIND_OPIMM;
        if (dec_f3 == 3'b001 || dec_f3 == 3'b101) begin
          if (!((dec_shift_hi == 12'd0) ||
                (dec_f3 == 3'b101 && dec_shift_hi == (12'h400 >> SHW)))) begin
            dec_kind = KIND_ILL;
          end
        end
      end
      OPC_BRANCH: begin
        if (dec_f3 != 3'b010 && dec_f3 != 3'b011) begin
          dec_kind = KIND_BRANCH;
        end
      end
      default: dec_kind = KIND_ILL;
    endcase
  end

  // Stage 1: capture decoded fields and operands on an accepted input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_kind  <= KIND_ILL;
      s1_f3    <= 3'd0;
      s1_rd    <= 5'd0;
      s1_imm   <= '0;
      s1_pc    <= '0;
      s1_bimm  <= '0;
      s1_rs1   <= '0;
      s1_rs2   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_kind <= dec_kind;
        s1_f3   <= dec_f3;
        s1_rd   <= bus.in_inst[11:7];
        s1_imm  <= dec_imm;
        s1_pc   <= bus.in_pc;
        s1_bimm <= dec_bimm;
        s1_rs1  <= bus.in_rs1;
        s1_rs2  <= bus.in_rs2;
      end
    end
  end

  assign ex_shamt = s1_imm[SHW-1:0];

  // Compute the OP-IMM result or the branch condition from S1.
  always_comb begin
    ex_rd_we   = 1'b0;
    ex_rd_data = '0;
    ex_br      = 1'b0;
    ex_taken   = 1'b0;
    ex_illegal = 1'b0;
    case (s1_kind)
      KIND_OPIMM: begin
        ex_rd_we = (s1_rd != 5'd0);
        case (s1_f3)
          3'b000:  ex_rd_data = s1_rs1 + s1_imm;
          3'b010:  ex_rd_data = XLEN'($signed(s1_rs1) < $signed(s1_imm));
          3'b011:  ex_rd_data = XLEN'(s1_rs1 < s1_imm);
          3'b100:  ex_rd_data = s1_rs1 ^ s1_imm;
          3'b110:  ex_rd_data = s1_rs1 | s1_imm;
          3'b111:  ex_rd_data = s1_rs1 & s1_imm;
          3'b001:  ex_rd_data = s1_rs1 << ex_shamt;
          default: ex_rd_data = s1_imm[10] ? $unsigned($signed(s1_rs1) >>> ex_shamt)
                                           : (s1_rs1 >> ex_shamt);
        endcase
      end
      KIND_BRANCH: begin
        ex_br = 1'b1;
        case (s1_f3)
          3'b000:  ex_taken = (s1_rs1 == s1_rs2);
          3'b001:  ex_taken = (s1_rs1 != s1_rs2);
          3'b100:  ex_taken = ($signed(s1_rs1) <  $signed(s1_rs2));
          3'b101:  ex_taken = ($signed(s1_rs1) >= $signed(s1_rs2));
          3'b110:  ex_taken = (s1_rs1 <  s1_rs2);
          3'b111:  ex_taken = (s1_rs1 >= s1_rs2);
          default: ex_taken = 1'b0;
        endcase
      end
      default: ex_illegal = 1'b1;
    endcase
  end

  // Stage 2: result registers that drive the output bus; hold while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_valid     <= 1'b0;
      bus.out_rd_we     <= 1'b0;
      bus.out_rd_addr   <= 5'd0;
      bus.out_rd_data   <= '0;
      bus.out_br        <= 1'b0;
      bus.out_br_taken  <= 1'b0;
      bus.out_br_target <= '0;
      bus.out_illegal   <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_rd_we     <= ex_rd_we;
        bus.out_rd_addr   <= s1_rd;
        bus.out_rd_data   <= ex_rd_data;
        bus.out_br        <= ex_br;
        bus.out_br_taken  <= ex_taken;
        bus.out_br_target <= s1_pc + s1_bimm;
        bus.out_illegal   <= ex_illegal;
      end
    end
  end

  // Count taken branches as they are handed to the consumer; flush does not clear it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.taken_cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && bus.out_br_taken) begin
      bus.taken_cnt <= bus.taken_cnt + CNT_W'(1);
    end
  end

endmodule
